// File: rtl/column_select_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | column_select_encoder                                                      |
// | Debounced left/right/drop buttons -> Connect4 cursor column and drop       |
// | request (valid/ready). Optional macro CURSOR_BLINK_EN blinks the one-hot   |
// | cursor drive while idle.                                                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module column_select_encoder #(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int BLINK_HALF_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_drop,
    input  logic [3:0] col_full,
    output logic [1:0] cursor_index,
    output logic [3:0] cursor_onehot,
    output logic       drop_valid,
    output logic [1:0] drop_column,
    input  logic       drop_ready,
    output logic       drop_reject
);

    localparam logic [7:0] C_DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_ACK = 1'b1
    } state_t;

    generate
        if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || BLINK_HALF_CYCLES < 1) begin : g_param_check
            $error("column_select_encoder: illegal parameter value");
        end
    endgenerate

    logic [2:0] w_raw;
    logic [2:0] w_evt;

    assign w_raw = {btn_drop, btn_right, btn_left};

    // Per button: 2-FF synchronizer, stability counter, registered rising-edge pulse.
    generate
        for (genvar b = 0; b < 3; b++) begin : g_btn
            logic       r_sync1;
            logic       r_sync2;
            logic       r_deb;
            logic       r_deb_d;
            logic       r_evt;
            logic [7:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_deb_d <= 1'b0;
                    r_evt   <= 1'b0;
                    r_cnt   <= 8'd0;
                end else begin
                    r_sync1 <= w_raw[b];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= 8'd0;
                    end else if (r_cnt == C_DB_LAST) begin
                        r_deb <= ~r_deb;
                        r_cnt <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    r_deb_d <= r_deb;
                    r_evt   <= r_deb & ~r_deb_d;
                end
            end

            assign w_evt[b] = r_evt;
        end
    endgenerate

    logic       w_left_evt;
    logic       w_right_evt;
    logic       w_drop_evt;
    logic       w_left_ok;
    logic       w_right_ok;
    logic [1:0] w_left_col;
    logic [1:0] w_right_col;
    logic [1:0] w_cursor_next;

    state_t     r_state;
    logic [1:0] r_cursor;
    logic [3:0] r_onehot;
    logic       r_drop_valid;
    logic [1:0] r_drop_column;
    logic       r_drop_reject;

    assign w_left_evt  = w_evt[0];
    assign w_right_evt = w_evt[1];
    assign w_drop_evt  = w_evt[2];

    // Scan farthest-first so the nearest non-full column wins; 2-bit math wraps.
    always_comb begin
        w_left_ok   = 1'b0;
        w_left_col  = r_cursor;
        w_right_ok  = 1'b0;
        w_right_col = r_cursor;
        for (int k = 3; k >= 1; k--) begin
            if (!col_full[r_cursor - 2'(k)]) begin
                w_left_ok  = 1'b1;
                w_left_col = r_cursor - 2'(k);
            end
            if (!col_full[r_cursor + 2'(k)]) begin
                w_right_ok  = 1'b1;
                w_right_col = r_cursor + 2'(k);
            end
        end
    end

    always_comb begin
        w_cursor_next = r_cursor;
        if (r_state == S_IDLE && !w_drop_evt) begin
            if (w_left_evt && !w_right_evt && w_left_ok) begin
                w_cursor_next = w_left_col;
            end else if (w_right_evt && !w_left_evt && w_right_ok) begin
                w_cursor_next = w_right_col;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cursor      <= 2'd0;
            r_drop_valid  <= 1'b0;
            r_drop_column <= 2'd0;
            r_drop_reject <= 1'b0;
        end else begin
            r_cursor      <= w_cursor_next;
            r_drop_reject <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_drop_evt) begin
                        if (!col_full[r_cursor]) begin
                            r_drop_column <= r_cursor;
                            r_drop_valid  <= 1'b1;
                            r_state       <= S_WAIT_ACK;
                        end else begin
                            r_drop_reject <= 1'b1;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (drop_ready) begin
                        r_drop_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam logic [31:0] C_BLINK_LAST = 32'(BLINK_HALF_CYCLES - 1);

    logic [31:0] r_blink_cnt;
    logic        r_blink_phase;
    logic        w_phase_next;
    logic        w_idle_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt   <= 32'd0;
            r_blink_phase <= 1'b1;
        end else if (r_blink_cnt == C_BLINK_LAST) begin
            r_blink_cnt   <= 32'd0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 32'd1;
        end
    end

    assign w_phase_next = (r_blink_cnt == C_BLINK_LAST) ? ~r_blink_phase : r_blink_phase;
    assign w_idle_next  = (r_state == S_IDLE && !(w_drop_evt && !col_full[r_cursor])) ||
                          (r_state == S_WAIT_ACK && drop_ready);

    // Blank only while idle; a pending request keeps the indicator solid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_onehot <= 4'b0001;
        end else if (!w_phase_next && w_idle_next) begin
            r_onehot <= 4'b0000;
        end else begin
            r_onehot <= 4'b0001 << w_cursor_next;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_onehot <= 4'b0001;
        end else begin
            r_onehot <= 4'b0001 << w_cursor_next;
        end
    end
`endif

    assign cursor_index  = r_cursor;
    assign cursor_onehot = r_onehot;
    assign drop_valid    = r_drop_valid;
    assign drop_column   = r_drop_column;
    assign drop_reject   = r_drop_reject;

endmodule
`default_nettype wire

// File: tb/tb_column_select_encoder.sv
`default_nettype none
// Directed bench for column_select_encoder: vector table of button presses plus
// hand-written latency, handshake, reject and reset-during-request sequences.
module tb_column_select_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_left;
    logic       btn_right;
    logic       btn_drop;
    logic [3:0] col_full;
    logic [1:0] cursor_index;
    logic [3:0] cursor_onehot;
    logic       drop_valid;
    logic [1:0] drop_column;
    logic       drop_ready;
    logic       drop_reject;

    int n_checks = 0;
    int n_err    = 0;
    int rej_cnt  = 0;
    int val_cnt  = 0;

    column_select_encoder #(
        .DEBOUNCE_CYCLES  (4),
        .BLINK_HALF_CYCLES(25000000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_drop     (btn_drop),
        .col_full     (col_full),
        .cursor_index (cursor_index),
        .cursor_onehot(cursor_onehot),
        .drop_valid   (drop_valid),
        .drop_column  (drop_column),
        .drop_ready   (drop_ready),
        .drop_reject  (drop_reject)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (drop_reject === 1'b1) rej_cnt++;
        if (drop_valid === 1'b1) val_cnt++;
    end

    typedef struct {
        logic [3:0] full;
        logic       l;
        logic       r;
        int         hold;
        logic [1:0] exp_idx;
        logic [3:0] exp_oh;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the release has settled.
    task automatic press(input logic l, input logic r, input logic d, input int hold);
        btn_left  = l;
        btn_right = r;
        btn_drop  = d;
        repeat (hold) @(negedge clk);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_drop  = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    initial begin
        int edges;
        int rej_base;
        int val_base;

        vecs[0]  = '{4'b0000, 1'b0, 1'b1, 6,  2'd2, 4'b0100};
        vecs[1]  = '{4'b0000, 1'b0, 1'b1, 6,  2'd3, 4'b1000};
        vecs[2]  = '{4'b0000, 1'b0, 1'b1, 6,  2'd0, 4'b0001};
        vecs[3]  = '{4'b0000, 1'b1, 1'b0, 6,  2'd3, 4'b1000};
        vecs[4]  = '{4'b0000, 1'b0, 1'b1, 3,  2'd3, 4'b1000};
        vecs[5]  = '{4'b0000, 1'b1, 1'b1, 8,  2'd3, 4'b1000};
        vecs[6]  = '{4'b0110, 1'b0, 1'b1, 6,  2'd0, 4'b0001};
        vecs[7]  = '{4'b0110, 1'b0, 1'b1, 6,  2'd3, 4'b1000};
        vecs[8]  = '{4'b0110, 1'b1, 1'b0, 6,  2'd0, 4'b0001};
        vecs[9]  = '{4'b1110, 1'b1, 1'b0, 6,  2'd0, 4'b0001};
        vecs[10] = '{4'b1110, 1'b0, 1'b1, 6,  2'd0, 4'b0001};
        vecs[11] = '{4'b0000, 1'b0, 1'b1, 6,  2'd1, 4'b0010};
        vecs[12] = '{4'b0000, 1'b0, 1'b1, 6,  2'd2, 4'b0100};

        reset      = 1'b1;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_drop   = 1'b0;
        col_full   = 4'b0000;
        drop_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_idx",    cursor_index,  2'd0);
        check("reset_onehot", cursor_onehot, 4'b0001);
        check("reset_valid",  drop_valid,    1'b0);
        check("reset_column", drop_column,   2'd0);
        check("reset_reject", drop_reject,   1'b0);

        // Move latency: cursor update 7 edges after the first edge that samples high.
        btn_right = 1'b1;
        @(posedge clk);
        edges = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (edges == 0 && cursor_index == 2'd1) edges = k;
        end
        check("move_latency", edges, 7);
        @(negedge clk);
        btn_right = 1'b0;
        repeat (14) @(negedge clk);
        check("held_idx",    cursor_index,  2'd1);
        check("held_onehot", cursor_onehot, 4'b0010);

        for (int i = 0; i < 13; i++) begin
            col_full = vecs[i].full;
            press(vecs[i].l, vecs[i].r, 1'b0, vecs[i].hold);
            check($sformatf("vec%0d_idx", i),    cursor_index,  vecs[i].exp_idx);
            check($sformatf("vec%0d_onehot", i), cursor_onehot, vecs[i].exp_oh);
        end
        col_full = 4'b0000;
        check("table_no_reject", rej_cnt, 0);
        check("table_no_valid",  val_cnt, 0);

        // Drop at column 2, held off by drop_ready=0; a left press meanwhile is ignored.
        press(1'b0, 1'b0, 1'b1, 6);
        check("wait_valid",  drop_valid,  1'b1);
        check("wait_column", drop_column, 2'd2);
        press(1'b1, 1'b0, 1'b0, 6);
        check("wait_left_idx",    cursor_index, 2'd2);
        check("wait_left_valid",  drop_valid,   1'b1);
        check("wait_left_column", drop_column,  2'd2);
        drop_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ack_valid", drop_valid, 1'b0);
        @(negedge clk);
        drop_ready = 1'b0;
        press(1'b0, 1'b1, 1'b0, 6);
        check("after_ack_move", cursor_index, 2'd3);

        // Reject on a full column under the cursor.
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b1, 1'b0, 1'b0, 6);
        check("pre_reject_idx", cursor_index, 2'd1);
        col_full = 4'b0010;
        rej_base = rej_cnt;
        val_base = val_cnt;
        press(1'b0, 1'b0, 1'b1, 6);
        check("reject_cycles", rej_cnt - rej_base, 1);
        check("reject_valid",  val_cnt - val_base, 0);
        check("reject_idx",    cursor_index, 2'd1);

        // Reset while a request is pending.
        col_full = 4'b0000;
        press(1'b0, 1'b0, 1'b1, 6);
        check("pre_reset_valid",  drop_valid,  1'b1);
        check("pre_reset_column", drop_column, 2'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_valid",  drop_valid,    1'b0);
        check("mid_reset_idx",    cursor_index,  2'd0);
        check("mid_reset_onehot", cursor_onehot, 4'b0001);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/column_select_encoder.md
Name: column_select_encoder

Overview:
- Player-facing column selector for the Connect4 board; the encode direction of the column decode path.
- Turns left/right/drop push-buttons into a held cursor column index plus its one-hot column drive (4 columns).
- Issues a valid/ready drop request to the game logic.
- Sits between board buttons and the game FSM; the one-hot output drives the column indicator LEDs.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required before a button level change is accepted; legal 1..255.
- BLINK_HALF_CYCLES, 25000000: cycles per half-period of cursor blink; used only with CURSOR_BLINK_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_left  in  1  raw asynchronous button, move cursor left
- btn_right  in  1  raw asynchronous button, move cursor right
- btn_drop  in  1  raw asynchronous button, request drop in cursor column
- col_full  in  4  bit i high = column i full (from game logic)
- cursor_index  out  2  current cursor column, binary
- cursor_onehot  out  4  one-hot of cursor_index (bit i = column i)
- drop_valid  out  1  drop request pending
- drop_column  out  2  column of pending request, stable while drop_valid
- drop_ready  in  1  game logic accepts request
- drop_reject  out  1  one-cycle pulse: drop pressed on a full column

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: cursor_index=0, cursor_onehot=4'b0001, drop_valid=0, drop_column=0, drop_reject=0.
- Reset also clears synchronizers, debounce counters and debounced levels, and returns the FSM to IDLE.
- Reset mid-request drops the pending request without a handshake.
- Input conditioning, per button:
  - 2-FF synchronizer, then a debounce counter.
  - The counter increments while the synchronized level differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A rising edge of the debounced level produces a one-cycle event.
  - Falling edges produce nothing.
- Latency: raw high first sampled at edge E0 gives the cursor/request register update at edge E0+DEBOUNCE_CYCLES+3.
- FSM states: IDLE, WAIT_ACK.
- IDLE, left event:
  - Target is the nearest column j=(i-k) mod 4, k=1..3, with col_full[j]=0.
  - If none exists, the cursor is unchanged.
  - Wrap-around: 0 goes to 3.
- IDLE, right event: same search with j=(i+k) mod 4; 3 wraps to 0.
- IDLE, left and right events in the same cycle: both ignored.
- IDLE, drop event:
  - col_full[cursor]=0: drop_column<=cursor_index, drop_valid<=1, go to WAIT_ACK.
  - Otherwise: drop_reject=1 for one cycle and stay in IDLE.
- Drop event coincident with a move event: drop takes priority; the move is discarded.
- WAIT_ACK:
  - drop_valid held high and drop_column stable.
  - All button events discarded (not queued).
  - On a cycle with drop_ready=1: drop_valid<=0 next edge, return to IDLE.
  - The handshake completes on the edge where drop_valid&&drop_ready.
- drop_ready while IDLE: ignored.
- The cursor never auto-moves; a column that becomes full under the cursor only causes a later drop_reject.
- cursor_onehot is a registered output, always equal to 1<<cursor_index (except when blanked by the option).

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- Defined:
  - Free-running counter toggles a blink phase every BLINK_HALF_CYCLES cycles; the phase is 1 after reset.
  - cursor_onehot = 4'b0000 while phase=0 and FSM is IDLE.
  - In WAIT_ACK, cursor_onehot is held solid.
  - cursor_index is unaffected.
- Undefined: no blink counter; cursor_onehot is always solid.

Test Plan (DEBOUNCE_CYCLES=4, col_full=0 unless stated):
- Reset, then right held 10 cycles: cursor_index 0→1 exactly 7 edges after the first sampled high; cursor_onehot 4'b0010; exactly one move per press.
- Cursor=3, right press → cursor 0; then left press → cursor 3; onehot 4'b0001 then 4'b1000.
- Glitch: btn_right high 3 cycles then low → no cursor change. Left+right pressed simultaneously → no change.
- col_full=4'b0110, cursor=0, right press → cursor 3. col_full=4'b1110, cursor=0, left/right press → stays 0.
- Cursor=2, drop with drop_ready=0 for 5 cycles → drop_valid=1, drop_column=2 held. A left press during the wait is ignored. drop_ready=1 → drop_valid=0 next edge.
- col_full[1]=1, cursor=1, drop press → drop_reject high exactly 1 cycle, drop_valid stays 0. Reset asserted during WAIT_ACK → drop_valid=0 and cursor=0 next edge.
